// File: rtl/decode_stage.sv
// Decode stage: splits a 16-bit instruction into fields, reads operands from a
// combinational write-first register file, tracks pending register writes to
// detect read-after-write hazards, and holds the ID/EX pipeline register plus
// a simple run/halt state machine.
module decode_stage #(
    parameter int NREGS = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    input  logic [15:0]  instruction_in,
    input  logic [W-1:0] pc_in,
    input  logic         flush,
    output logic [3:0]   rf_addr_a,
    output logic [3:0]   rf_addr_b,
    input  logic [W-1:0] rf_data_a,
    input  logic [W-1:0] rf_data_b,
    input  logic         wb_en,
    input  logic [3:0]   wb_addr,
    output logic         stall,
    output logic         valid_out,
    output logic [2:0]   ALUop,
    output logic [W-1:0] srcA,
    output logic [W-1:0] srcB,
    output logic [W-1:0] store_data,
    output logic [3:0]   rd,
    output logic         reg_write,
    output logic         mem_read,
    output logic         mem_write,
    output logic         branch,
    output logic [W-1:0] pc_out,
    output logic         illegal,
    output logic         halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // Sign-extend a 4-bit immediate to the datapath width.
    function automatic logic [W-1:0] sext4(input logic [3:0] v);
        return {{(W-4){v[3]}}, v};
    endfunction

    // Sign-extend an 8-bit immediate to the datapath width.
    function automatic logic [W-1:0] sext8(input logic [7:0] v);
        return {{(W-8){v[7]}}, v};
    endfunction

    // A source is busy when its write is still pending and is not being
    // written back this very cycle (the write-first file forwards that value).
    function automatic logic src_busy(input logic [NREGS-1:0] pend,
                                      input logic             wbe,
                                      input logic [3:0]       wba,
                                      input logic [3:0]       src);
        return pend[src] & ~(wbe & (wba == src));
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [NREGS-1:0]   pending_r;
    logic [NREGS-1:0]   pending_next_s;

    logic [3:0]   op_s;
    logic [3:0]   rd_field_s;
    logic         use_a_s;
    logic         use_b_s;
    logic [2:0]   dec_alu_s;
    logic [W-1:0] dec_srca_s;
    logic [W-1:0] dec_srcb_s;
    logic [W-1:0] dec_store_s;
    logic [3:0]   dec_rd_s;
    logic         dec_rw_s;
    logic         dec_mr_s;
    logic         dec_mw_s;
    logic         dec_br_s;
    logic         is_halt_s;
    logic         is_illegal_s;
    logic         hazard_s;
    logic         issue_s;

    assign op_s       = instruction_in[15:12];
    assign rd_field_s = instruction_in[11:8];

    // Instruction decode: operand addresses, source usage and control fields.
    always_comb begin
        rf_addr_a    = instruction_in[7:4];
        rf_addr_b    = instruction_in[3:0];
        use_a_s      = 1'b0;
        use_b_s      = 1'b0;
        dec_alu_s    = 3'b000;
        dec_srca_s   = {W{1'b0}};
        dec_srcb_s   = {W{1'b0}};
        dec_store_s  = {W{1'b0}};
        dec_rd_s     = rd_field_s;
        dec_rw_s     = 1'b0;
        dec_mr_s     = 1'b0;
        dec_mw_s     = 1'b0;
        dec_br_s     = 1'b0;
        is_halt_s    = 1'b0;
        is_illegal_s = 1'b0;
        case (op_s)
            4'h0: begin
                dec_rd_s = 4'h0;
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                use_a_s    = 1'b1;
                use_b_s    = 1'b1;
                dec_alu_s  = op_s[2:0];
                dec_srca_s = rf_data_a;
                dec_srcb_s = rf_data_b;
                dec_rw_s   = 1'b1;
            end
            4'h6: begin
                use_a_s    = 1'b1;
                dec_alu_s  = 3'b001;
                dec_srca_s = rf_data_a;
                dec_srcb_s = sext4(instruction_in[3:0]);
                dec_rw_s   = 1'b1;
            end
            4'h8: begin
                use_a_s    = 1'b1;
                dec_alu_s  = 3'b001;
                dec_srca_s = rf_data_a;
                dec_srcb_s = sext4(instruction_in[3:0]);
                dec_mr_s   = 1'b1;
                dec_rw_s   = 1'b1;
            end
            4'h9: begin
                // The rd field names the register whose value is stored.
                rf_addr_b   = rd_field_s;
                use_a_s     = 1'b1;
                use_b_s     = 1'b1;
                dec_alu_s   = 3'b001;
                dec_srca_s  = rf_data_a;
                dec_srcb_s  = sext4(instruction_in[3:0]);
                dec_store_s = rf_data_b;
                dec_mw_s    = 1'b1;
            end
            4'hC: begin
                dec_alu_s  = 3'b001;
                dec_srca_s = pc_in;
                dec_srcb_s = sext8(instruction_in[7:0]);
                dec_br_s   = 1'b1;
            end
            4'hF: begin
                is_halt_s = 1'b1;
                dec_rd_s  = 4'h0;
            end
            default: begin
                is_illegal_s = 1'b1;
                dec_rd_s     = 4'h0;
            end
        endcase
    end

    // Hazard, stall and issue qualification.
    always_comb begin
        hazard_s = (use_a_s & src_busy(pending_r, wb_en, wb_addr, rf_addr_a)) |
                   (use_b_s & src_busy(pending_r, wb_en, wb_addr, rf_addr_b));
        stall    = (valid_in & hazard_s & ~flush) | (state_r == ST_HALTED);
        issue_s  = valid_in & ~stall & ~flush & (state_r == ST_RUN);
    end

    // Scoreboard update: writeback clears first so a same-cycle issue sets.
    always_comb begin
        pending_next_s = pending_r;
        if (wb_en) begin
            pending_next_s[wb_addr] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (issue_s && dec_rw_s) begin
            pending_next_s[dec_rd_s] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    // Run/halt next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (issue_s && is_halt_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_next_s = ST_HALTED;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State and scoreboard registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_RUN;
            pending_r <= {NREGS{1'b0}};
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
        end
    end

    // ID/EX register: decoded instruction on issue, otherwise a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out  <= 1'b0;
            ALUop      <= 3'b000;
            srcA       <= {W{1'b0}};
            srcB       <= {W{1'b0}};
            store_data <= {W{1'b0}};
            rd         <= 4'h0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            pc_out     <= {W{1'b0}};
            illegal    <= 1'b0;
        end else if (issue_s && !is_halt_s) begin
            valid_out  <= 1'b1;
            ALUop      <= dec_alu_s;
            srcA       <= dec_srca_s;
            srcB       <= dec_srcb_s;
            store_data <= dec_store_s;
            rd         <= dec_rd_s;
            reg_write  <= dec_rw_s;
            mem_read   <= dec_mr_s;
            mem_write  <= dec_mw_s;
            branch     <= dec_br_s;
            pc_out     <= pc_in;
            illegal    <= is_illegal_s;
        end else begin
            valid_out  <= 1'b0;
            ALUop      <= 3'b000;
            srcA       <= {W{1'b0}};
            srcB       <= {W{1'b0}};
            store_data <= {W{1'b0}};
            rd         <= 4'h0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            pc_out     <= {W{1'b0}};
            illegal    <= 1'b0;
        end
    end

    assign halted = (state_r == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: a table of per-cycle vectors followed
// by hand-written sequences for halt and asynchronous reset.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [15:0] instruction_in;
    logic [15:0] pc_in;
    logic        flush;
    logic [3:0]  rf_addr_a;
    logic [3:0]  rf_addr_b;
    logic [15:0] rf_data_a;
    logic [15:0] rf_data_b;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic        stall;
    logic        valid_out;
    logic [2:0]  ALUop;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic [15:0] store_data;
    logic [3:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [15:0] pc_out;
    logic        illegal;
    logic        halted;

    int checks;
    int failures;

    decode_stage #(.NREGS(16), .W(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .instruction_in(instruction_in), .pc_in(pc_in), .flush(flush),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .stall(stall),
        .valid_out(valid_out), .ALUop(ALUop), .srcA(srcA), .srcB(srcB),
        .store_data(store_data), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .pc_out(pc_out), .illegal(illegal), .halted(halted)
    );

    // Register-file model: each register holds a value derived from its index.
    assign rf_data_a = {4'hA, rf_addr_a, 4'hB, rf_addr_a};
    assign rf_data_b = {4'hC, rf_addr_b, 4'hD, rf_addr_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [15:0] ins;
        logic [15:0] pc;
        logic        fl;
        logic        wbe;
        logic [3:0]  wba;
        logic        e_stall;
        logic        e_vo;
        logic [2:0]  e_alu;
        logic [15:0] e_sa;
        logic [15:0] e_sb;
        logic [15:0] e_sd;
        logic [3:0]  e_rd;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
        logic        e_br;
        logic        e_ill;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic vld, logic [15:0] ins, logic [15:0] pc,
                                logic fl, logic wbe, logic [3:0] wba,
                                logic st, logic vo, logic [2:0] alu,
                                logic [15:0] sa, logic [15:0] sb, logic [15:0] sd,
                                logic [3:0] r, logic rw, logic mr, logic mw,
                                logic br, logic ill);
        vec_t v;
        v.vld = vld; v.ins = ins; v.pc = pc; v.fl = fl; v.wbe = wbe; v.wba = wba;
        v.e_stall = st; v.e_vo = vo; v.e_alu = alu; v.e_sa = sa; v.e_sb = sb;
        v.e_sd = sd; v.e_rd = r; v.e_rw = rw; v.e_mr = mr; v.e_mw = mw;
        v.e_br = br; v.e_ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [15:0] ins, input logic [15:0] pc,
                         input logic fl, input logic wbe, input logic [3:0] wba);
        valid_in = vld; instruction_in = ins; pc_in = pc;
        flush = fl; wb_en = wbe; wb_addr = wba;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        // vld ins pc fl wbe wba | stall vo alu srcA srcB store rd rw mr mw br ill
        vecs[0]  = mk(1'b1, 16'h1123, 16'h0002, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b001, 16'hA2B2, 16'hC3D3, 16'h0000, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 16'h2415, 16'h0004, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 16'h2415, 16'h0004, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 16'h2415, 16'h0004, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 3'b010, 16'hA1B1, 16'hC5D5, 16'h0000, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 16'h667F, 16'h0006, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b001, 16'hA7B7, 16'hFFFF, 16'h0000, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 16'hC080, 16'h0010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b001, 16'h0010, 16'hFF80, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 16'h5840, 16'h0012, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 16'h5840, 16'h0012, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 16'h4501, 16'h0014, 1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 3'b100, 16'hA0B0, 16'hC1D1, 16'h0000, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 16'h8950, 16'h0016, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 16'h8950, 16'h0016, 1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 3'b001, 16'hA5B5, 16'h0000, 16'h0000, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 16'h9473, 16'h0018, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 16'h9473, 16'h0018, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 3'b001, 16'hA7B7, 16'h0003, 16'hC4D4, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 16'h7ABC, 16'h001A, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 16'h0000, 16'h001C, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 16'h1169, 16'h001E, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        reset = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);
        #2;
        chk("reset_valid_out", {15'd0, valid_out}, 16'h0000);
        chk("reset_rd", {12'd0, rd}, 16'h0000);
        chk("reset_reg_write", {15'd0, reg_write}, 16'h0000);
        chk("reset_halted", {15'd0, halted}, 16'h0000);
        chk("reset_illegal", {15'd0, illegal}, 16'h0000);
        chk("reset_stall", {15'd0, stall}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].ins, vecs[i].pc, vecs[i].fl, vecs[i].wbe, vecs[i].wba);
            #1;
            chk($sformatf("v%0d_stall", i), {15'd0, stall}, {15'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_out", i), {15'd0, valid_out}, {15'd0, vecs[i].e_vo});
            chk($sformatf("v%0d_ALUop", i), {13'd0, ALUop}, {13'd0, vecs[i].e_alu});
            chk($sformatf("v%0d_srcA", i), srcA, vecs[i].e_sa);
            chk($sformatf("v%0d_srcB", i), srcB, vecs[i].e_sb);
            chk($sformatf("v%0d_store_data", i), store_data, vecs[i].e_sd);
            chk($sformatf("v%0d_rd", i), {12'd0, rd}, {12'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_ctrl", i), {11'd0, reg_write, mem_read, mem_write, branch, illegal},
                {11'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_br, vecs[i].e_ill});
            chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].e_vo ? vecs[i].pc : 16'h0000);
        end

        // HALT issues as a bubble and then stalls forever.
        @(negedge clk);
        drive(1'b1, 16'hF000, 16'h0020, 1'b0, 1'b0, 4'h0);
        #1;
        chk("halt_issue_stall", {15'd0, stall}, 16'h0000);
        @(posedge clk);
        #1;
        chk("halt_valid_out", {15'd0, valid_out}, 16'h0000);
        chk("halt_halted", {15'd0, halted}, 16'h0001);
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0022, 1'b0, 1'b0, 4'h0);
        #1;
        chk("halted_stall_idle", {15'd0, stall}, 16'h0001);
        @(negedge clk);
        drive(1'b1, 16'h1123, 16'h0024, 1'b0, 1'b0, 4'h0);
        #1;
        chk("halted_stall_valid", {15'd0, stall}, 16'h0001);
        @(posedge clk);
        #1;
        chk("halted_no_issue", {15'd0, valid_out}, 16'h0000);
        chk("halted_stays", {15'd0, halted}, 16'h0001);

        // Mid-cycle reset while halted: back to RUN with an empty scoreboard.
        #2;
        reset = 1'b0;
        #1;
        chk("rst_halted_clears", {15'd0, halted}, 16'h0000);
        chk("rst_stall_low", {15'd0, stall}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'h1169, 16'h0026, 1'b0, 1'b0, 4'h0);
        #1;
        chk("post_rst_no_hazard", {15'd0, stall}, 16'h0000);
        @(posedge clk);
        #1;
        chk("post_rst_valid_out", {15'd0, valid_out}, 16'h0001);
        chk("post_rst_rd", {12'd0, rd}, 16'h0001);
        chk("post_rst_srcA", srcA, 16'hA6B6);
        chk("post_rst_srcB", srcB, 16'hC9D9);

        // Asynchronous reset clears live ID/EX contents immediately.
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid_out", {15'd0, valid_out}, 16'h0000);
        chk("async_rst_reg_write", {15'd0, reg_write}, 16'h0000);
        chk("async_rst_rd", {12'd0, rd}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage at the consuming end of the fetch/decode pipeline register. It accepts one 16-bit instruction per cycle and splits it into fields. It reads operands through a combinational register-file port, detects read-after-write hazards with a pending-write scoreboard, and back-pressures fetch with `stall`. It also holds the registered decode/execute (ID/EX) outputs and a run/halt state machine.

## Interface
- `NREGS`, 16: register count; register addresses are 4 bits.
- `W`, 16: datapath width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  `instruction_in` holds a real instruction.
- `instruction_in`  in  16  instruction from the fetch/decode register.
- `pc_in`  in  16  PC of `instruction_in`.
- `flush`  in  1  branch redirect from execute; discards the current decode instruction.
- `rf_addr_a`, `rf_addr_b`  out  4  register-file read addresses (combinational).
- `rf_data_a`, `rf_data_b`  in  16  register-file read data. The register file is write-first.
- `wb_en`  in  1  writeback occurring this cycle.
- `wb_addr`  in  4  writeback destination register.
- `stall`  out  1  fetch holds PC and the fetch/decode register (combinational).
- `valid_out`, `ALUop[2:0]`, `srcA[15:0]`, `srcB[15:0]`, `store_data[15:0]`, `rd[3:0]`, `reg_write`, `mem_read`, `mem_write`, `branch`, `pc_out[15:0]`  out: ID/EX register contents.
- `illegal`  out  1  one-cycle pulse for an undefined opcode.
- `halted`  out  1  the state machine is in HALTED.

## Operation
- Instruction fields: `op` = [15:12], `rd` = [11:8], `rs1` = [7:4], `rs2`/imm4 = [3:0], imm8 = [7:0].
- Opcode map:
  - 0000 NOP.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR: `ALUop` = op[2:0], A = `rs1`, B = `rs2`, `reg_write` = 1.
  - 0110 ADDI: A = `rs1`, `srcB` = sext(imm4), `ALUop` = 001.
  - 1000 LOAD: A = `rs1`, `srcB` = sext(imm4), `ALUop` = 001, `mem_read` = 1, `reg_write` = 1.
  - 1001 STORE: `rf_addr_b` = `rd`, `store_data` = `rf_data_b`, `srcB` = sext(imm4), `mem_write` = 1, no `reg_write`.
  - 1100 BR: `srcA` = `pc_in`, `srcB` = sext(imm8), `ALUop` = 001, `branch` = 1, no register sources.
  - 1111 HALT.
  - Any other opcode: issued as a NOP, and `illegal` pulses.
- Scoreboard: a 16-bit `pending` bitmap.
  - Set `pending[rd]` when an instruction with `reg_write` issues.
  - Clear `pending[wb_addr]` when `wb_en` is high.
  - Set and clear of the same bit in one cycle: set wins.
- `hazard`: some used source register `s` has `pending[s]` set, and it is not the case that `wb_en` is high with `wb_addr == s`. A same-cycle writeback is forwarded through the write-first register file.
- `stall` = `valid_in` & `hazard` & ~`flush`, or state == HALTED.
- Issue condition: `valid_in` & ~`stall` & ~`flush` & state == RUN. On issue, the ID/EX register loads the decoded instruction with `valid_out` = 1.
  - Otherwise the ID/EX register loads a bubble: `valid_out`, `reg_write`, `mem_read`, `mem_write`, `branch` all 0, and data fields 0.
- State machine:
  - RUN → HALTED on issue of HALT.
  - HALTED → HALTED until reset.
  - HALT issues as a bubble (`valid_out` = 0).
- `flush` has priority over a hazard: the discarded instruction never sets `pending` and never halts.
- Register 0 is an ordinary register; it is not hard-wired to zero.

## Timing
- Reset (async assert, sync release):
  - `pending` = 0, state = RUN, all ID/EX outputs 0, `illegal` = 0, `halted` = 0.
  - `stall` = 0 while in reset.
- Latency: an instruction presented with `valid_in` appears on the ID/EX outputs one clock after its issue edge.
- Stall behaviour: `stall` rises in the same cycle the hazard is seen. The instruction is re-evaluated every cycle and issues on the first cycle without a hazard. Each stall cycle emits exactly one bubble.
- Back-to-back dependency: an ADD writing r3 followed by a consumer of r3 stalls until the cycle `wb_en` with `wb_addr` = 3 occurs. The consumer issues in that same cycle.
- Reset mid-stall or while HALTED: returns to RUN with `pending` = 0.

## Test plan
- Reset: drive `reset` = 0 mid-cycle → all outputs 0 immediately. After release, send ADD r1,r2,r3 (0x1123) → next edge gives `valid_out` = 1, `ALUop` = 001, `rd` = 1, `reg_write` = 1.
- RAW hazard: issue 0x1123, then 0x2415 (reads r1) with no writeback → `stall` = 1 and bubbles are emitted. Pulse `wb_en` with `wb_addr` = 1 → `stall` = 0 that cycle and SUB issues at the next edge.
- Immediate sign extension: ADDI with imm4 = 0xF → `srcB` = 0xFFFF. BR with imm8 = 0x80 at `pc_in` = 0x0010 → `srcA` = 0x0010, `srcB` = 0xFF80, `branch` = 1.
- Flush during stall: a hazarded instruction with `flush` = 1 → `stall` = 0, a bubble is emitted, and `pending` is unchanged.
- Simultaneous set/clear: issue a writer to r5 in the same cycle as `wb_en` with `wb_addr` = 5 → `pending[5]` stays 1, and a following r5 reader stalls.
- HALT and illegal: opcode 0x7 → `illegal` pulses for one cycle and a NOP is issued. 0xF000 → `halted` = 1 and `stall` = 1 indefinitely. Reset → back to RUN.
